dino_game_ctrl: RTL and testbench
=================================

Name: dino_game_ctrl

Overview:
- Game-control stage directly upstream of the VGA render/obstacle top level.
- Conditions the raw jump/duck buttons and runs the START/GRACE/PLAY/DEAD state machine.
- Drives game_state, dino_jump and dino_duck into the renderer.
- Consumes the renderer's per-pixel collision flag and animate frame strobe, and keeps the current score and the high score.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable i_clk cycles before a button change is accepted (10 ms at 100 MHz).
- GRACE_FRAMES, 120: frames spent in GRACE before PLAY.
- DEAD_HOLD_FRAMES, 60: frames in DEAD during which restart is ignored.
- COLLISION_MIN, 4: collision pixels within one frame needed to kill.
- SCORE_DIV, 6: PLAY frames per score increment.
- SCORE_W, 14: score counter width.
- START_STATE, 2'b00: encoding of the START state.
- GRACE_STATE, 2'b01: encoding of the GRACE state.
- PLAY_STATE, 2'b10: encoding of the PLAY state.
- DEAD_STATE, 2'b11: encoding of the DEAD state.

Ports:
- i_clk  in  1  system clock, 100 MHz.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_btn_jump  in  1  raw asynchronous jump button, active-high.
- i_btn_duck  in  1  raw asynchronous duck button, active-high.
- i_animate  in  1  one-cycle frame strobe from the VGA timing generator.
- i_collision  in  1  per-pixel dino/obstacle overlap flag from the renderer.
- o_game_state  out  2  current state encoding.
- o_dino_jump  out  1  one-cycle jump request.
- o_dino_duck  out  1  duck level.
- o_score  out  SCORE_W  current score.
- o_high_score  out  SCORE_W  best score since reset.

Behaviour:
- Clock and reset:
  - One clock domain, i_clk.
  - i_rst_n low at a rising edge puts every register in its reset state on that edge; this holds mid-game too.
- Reset values:
  - o_game_state = START_STATE.
  - o_dino_jump = 0, o_dino_duck = 0.
  - o_score = 0, o_high_score = 0.
  - Synchronizers 0, debounced levels 0, all counters 0.
- Button conditioning (each button, independently):
  - 2-flop synchronizer, then a debounce counter.
  - The counter resets whenever the synced value equals the debounced level.
  - The debounced level toggles when the counter reaches DEBOUNCE_CYCLES-1.
  - Latency from a stable raw change to the debounced change is DEBOUNCE_CYCLES+2 cycles.
  - jump_press is a one-cycle pulse on the debounced 0->1 edge.
- Outputs:
  - o_dino_jump = jump_press registered, qualified by state GRACE or PLAY.
  - o_dino_duck = debounced duck level, forced 0 in START and DEAD; registered.
  - If jump and duck are both active, both are output; priority is resolved downstream.
- Collision filter:
  - hit_cnt (saturating at COLLISION_MIN) increments on each i_clk where i_collision=1 and the state is PLAY.
  - hit_cnt clears on i_animate.
  - If an increment and i_animate coincide, the clear wins.
  - death is asserted when hit_cnt reaches COLLISION_MIN.
- State machine (one transition per cycle, registered):
  - START -> GRACE on jump_press. Clears o_score, frame_cnt, score_div_cnt.
  - GRACE:
    - frame_cnt increments on i_animate.
    - When frame_cnt = GRACE_FRAMES-1 and i_animate arrives, go to PLAY and clear frame_cnt.
    - Collisions are ignored.
  - PLAY:
    - Go to DEAD when death is asserted; clear frame_cnt and hit_cnt.
    - Otherwise, on i_animate, score_div_cnt increments. When it is SCORE_DIV-1 it wraps to 0 and o_score increments, saturating at all-ones.
    - If death and i_animate occur in the same cycle, DEAD wins and the score does not increment.
  - DEAD:
    - On entry cycle, o_high_score <= max(o_high_score, o_score) (unsigned compare, equal leaves it unchanged).
    - o_score holds.
    - frame_cnt counts i_animate up to DEAD_HOLD_FRAMES and saturates there.
    - jump_press with frame_cnt < DEAD_HOLD_FRAMES is discarded (no queuing).
    - jump_press with frame_cnt = DEAD_HOLD_FRAMES goes to GRACE; clears o_score, frame_cnt, score_div_cnt.
  - The unused encoding cannot occur, since all four encodings are legal.
- Frame counting:
  - frame_cnt width is clog2(max(GRACE_FRAMES, DEAD_HOLD_FRAMES)+1).
- All outputs are registered, with no combinational input-to-output path.

Test Plan:
- Reset then hold i_btn_jump=1 with DEBOUNCE_CYCLES=8 -> o_game_state 00 -> 01 exactly 11 cycles after the raw edge; o_dino_jump=0 (START press consumed).
- Bounce i_btn_jump 0/1 every 3 cycles for 40 cycles, DEBOUNCE_CYCLES=8 -> no jump_press, state unchanged; then stable high -> exactly one press.
- GRACE_FRAMES=3: pulse i_animate 3 times with i_collision=1 throughout -> PLAY entered the cycle after the third strobe; no DEAD.
- PLAY, SCORE_DIV=2, 10 frames, no collision -> o_score=5. Then 3 collision cycles in one frame, COLLISION_MIN=4 -> still PLAY. Then 4 collision cycles -> DEAD, o_high_score=5.
- DEAD, DEAD_HOLD_FRAMES=2: jump after 1 frame -> stays 11; jump after 2 frames -> 01, o_score=0, o_high_score=5; a later game scoring 3 leaves o_high_score=5.
- Drive i_rst_n=0 for one cycle while in PLAY with o_score=7 and duck held -> next cycle state 00, o_score 0, o_high_score 0, o_dino_duck 0.

Source files
------------

// File: rtl/dino_game_ctrl.sv
// rtl/dino_game_ctrl.sv - button conditioning, game state machine, collision filter and scoring
module dino_game_ctrl #(
   parameter int         DEBOUNCE_CYCLES  = 1000000,
   parameter int         GRACE_FRAMES     = 120,
   parameter int         DEAD_HOLD_FRAMES = 60,
   parameter int         COLLISION_MIN    = 4,
   parameter int         SCORE_DIV        = 6,
   parameter int         SCORE_W          = 14,
   parameter logic [1:0] START_STATE      = 2'b00,
   parameter logic [1:0] GRACE_STATE      = 2'b01,
   parameter logic [1:0] PLAY_STATE       = 2'b10,
   parameter logic [1:0] DEAD_STATE       = 2'b11
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_btn_jump,
   input  logic               i_btn_duck,
   input  logic               i_animate,
   input  logic               i_collision,
   output logic [1:0]         o_game_state,
   output logic               o_dino_jump,
   output logic               o_dino_duck,
   output logic [SCORE_W-1:0] o_score,
   output logic [SCORE_W-1:0] o_high_score
);

   localparam int FRAME_MAX = (GRACE_FRAMES > DEAD_HOLD_FRAMES) ? GRACE_FRAMES : DEAD_HOLD_FRAMES;
   localparam int FRAME_W   = $clog2(FRAME_MAX + 1);
   localparam int DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HIT_W     = $clog2(COLLISION_MIN + 1);
   localparam int DIV_W     = $clog2(SCORE_DIV + 1);

   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HIT_W-1:0]   HIT_MAX    = HIT_W'(COLLISION_MIN);
   localparam logic [FRAME_W-1:0] GRACE_LAST = FRAME_W'(GRACE_FRAMES - 1);
   localparam logic [FRAME_W-1:0] HOLD_MAX   = FRAME_W'(DEAD_HOLD_FRAMES);
   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCORE_DIV - 1);

   typedef enum logic [1:0] {
      ST_START = START_STATE,
      ST_GRACE = GRACE_STATE,
      ST_PLAY  = PLAY_STATE,
      ST_DEAD  = DEAD_STATE
   } state_t;

   // bit 0 = jump button, bit 1 = duck button
   logic [1:0]         sync1_q, sync1_d;
   logic [1:0]         sync2_q, sync2_d;
   logic [1:0]         deb_q, deb_d;
   logic [DEB_W-1:0]   deb_cnt_q [2];
   logic [DEB_W-1:0]   deb_cnt_d [2];
   logic               jump_prev_q, jump_prev_d;
   logic [HIT_W-1:0]   hit_cnt_q, hit_cnt_d;
   state_t             state_q, state_d;
   logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] high_q, high_d;
   logic               jump_out_q, jump_out_d;
   logic               duck_out_q, duck_out_d;

   logic jump_press;
   logic death;
   logic active;

   assign jump_press = deb_q[0] & ~jump_prev_q;
   assign death      = (hit_cnt_q == HIT_MAX);
   assign active     = (state_q == ST_GRACE) || (state_q == ST_PLAY);

   // Synchronize both buttons and accept a new level only after it has been stable long enough
   always_comb begin
      sync1_d     = {i_btn_duck, i_btn_jump};
      sync2_d     = sync1_q;
      deb_d       = deb_q;
      jump_prev_d = deb_q[0];
      for (int b = 0; b < 2; b++) begin
         deb_cnt_d[b] = deb_cnt_q[b];
         if (sync2_q[b] == deb_q[b]) begin
            deb_cnt_d[b] = '0;
         end else if (deb_cnt_q[b] == DEB_LAST) begin
            deb_d[b]     = ~deb_q[b];
            deb_cnt_d[b] = '0;
         end else begin
            deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
         end
      end
   end

   // Game state machine, collision filter, frame/score counters and registered outputs
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      div_cnt_d   = div_cnt_q;
      score_d     = score_q;
      high_d      = high_q;
      hit_cnt_d   = hit_cnt_q;
      jump_out_d  = jump_press & active;
      duck_out_d  = deb_q[1] & active;

      // the frame strobe clears the count even when a hit lands in the same cycle
      if (i_animate) begin
         hit_cnt_d = '0;
      end else if (i_collision && (state_q == ST_PLAY) && (hit_cnt_q < HIT_MAX)) begin
         hit_cnt_d = hit_cnt_q + 1'b1;
      end

      case (state_q)
         ST_START: begin
            if (jump_press) begin
               state_d     = ST_GRACE;
               score_d     = '0;
               frame_cnt_d = '0;
               div_cnt_d   = '0;
            end
         end
         ST_GRACE: begin
            if (i_animate) begin
               if (frame_cnt_q == GRACE_LAST) begin
                  state_d     = ST_PLAY;
                  frame_cnt_d = '0;
               end else begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end
            end
         end
         ST_PLAY: begin
            if (death) begin
               state_d     = ST_DEAD;
               frame_cnt_d = '0;
               hit_cnt_d   = '0;
               high_d      = (score_q > high_q) ? score_q : high_q;
            end else if (i_animate) begin
               if (div_cnt_q == DIV_LAST) begin
                  div_cnt_d = '0;
                  if (score_q != {SCORE_W{1'b1}}) begin
                     score_d = score_q + 1'b1;
                  end
               end else begin
                  div_cnt_d = div_cnt_q + 1'b1;
               end
            end
         end
         ST_DEAD: begin
            // presses during the hold window are dropped, not remembered
            if (jump_press && (frame_cnt_q == HOLD_MAX)) begin
               state_d     = ST_GRACE;
               score_d     = '0;
               frame_cnt_d = '0;
               div_cnt_d   = '0;
            end else if (i_animate && (frame_cnt_q < HOLD_MAX)) begin
               frame_cnt_d = frame_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_START;
         end
      endcase
   end

   // All state registers with synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         deb_q        <= '0;
         deb_cnt_q[0] <= '0;
         deb_cnt_q[1] <= '0;
         jump_prev_q  <= 1'b0;
         hit_cnt_q    <= '0;
         state_q      <= ST_START;
         frame_cnt_q  <= '0;
         div_cnt_q    <= '0;
         score_q      <= '0;
         high_q       <= '0;
         jump_out_q   <= 1'b0;
         duck_out_q   <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         deb_q        <= deb_d;
         deb_cnt_q[0] <= deb_cnt_d[0];
         deb_cnt_q[1] <= deb_cnt_d[1];
         jump_prev_q  <= jump_prev_d;
         hit_cnt_q    <= hit_cnt_d;
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         div_cnt_q    <= div_cnt_d;
         score_q      <= score_d;
         high_q       <= high_d;
         jump_out_q   <= jump_out_d;
         duck_out_q   <= duck_out_d;
      end
   end

   assign o_game_state = state_q;
   assign o_dino_jump  = jump_out_q;
   assign o_dino_duck  = duck_out_q;
   assign o_score      = score_q;
   assign o_high_score = high_q;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// tb/tb_dino_game_ctrl.sv - vector table, corner sequences and random run against a reference model
module tb_dino_game_ctrl;

   localparam int DEB  = 8;
   localparam int GF   = 3;
   localparam int HOLD = 2;
   localparam int CMIN = 4;
   localparam int DIV  = 2;
   localparam int SW   = 4;
   localparam int SMAX = (1 << SW) - 1;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_btn_jump;
   logic          i_btn_duck;
   logic          i_animate;
   logic          i_collision;
   logic [1:0]    o_game_state;
   logic          o_dino_jump;
   logic          o_dino_duck;
   logic [SW-1:0] o_score;
   logic [SW-1:0] o_high_score;

   always #5 i_clk = ~i_clk;

   dino_game_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .GRACE_FRAMES    (GF),
      .DEAD_HOLD_FRAMES(HOLD),
      .COLLISION_MIN   (CMIN),
      .SCORE_DIV       (DIV),
      .SCORE_W         (SW)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_btn_jump  (i_btn_jump),
      .i_btn_duck  (i_btn_duck),
      .i_animate   (i_animate),
      .i_collision (i_collision),
      .o_game_state(o_game_state),
      .o_dino_jump (o_dino_jump),
      .o_dino_duck (o_dino_duck),
      .o_score     (o_score),
      .o_high_score(o_high_score)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: 0=START 1=GRACE 2=PLAY 3=DEAD
   int m_raw1 [2];
   int m_raw2 [2];
   int m_lvl  [2];
   int m_run  [2];
   int m_lvl_jump_old;
   int m_state, m_frames, m_sub, m_score, m_high, m_hits, m_ojump, m_oduck;

   function automatic void model_step();
      int press, dead_now, act;
      if (!i_rst_n) begin
         for (int b = 0; b < 2; b++) begin
            m_raw1[b] = 0; m_raw2[b] = 0; m_lvl[b] = 0; m_run[b] = 0;
         end
         m_lvl_jump_old = 0;
         m_state = 0; m_frames = 0; m_sub = 0; m_score = 0; m_high = 0;
         m_hits = 0; m_ojump = 0; m_oduck = 0;
         return;
      end
      press    = (m_lvl[0] == 1 && m_lvl_jump_old == 0) ? 1 : 0;
      dead_now = (m_hits >= CMIN) ? 1 : 0;
      act      = (m_state == 1 || m_state == 2) ? 1 : 0;
      m_ojump  = press & act;
      m_oduck  = m_lvl[1] & act;
      m_lvl_jump_old = m_lvl[0];
      // a level is accepted after DEB consecutive sampled cycles that disagree with it
      for (int b = 0; b < 2; b++) begin
         if (m_raw2[b] != m_lvl[b]) begin
            m_run[b] = m_run[b] + 1;
            if (m_run[b] == DEB) begin
               m_lvl[b] = 1 - m_lvl[b];
               m_run[b] = 0;
            end
         end else begin
            m_run[b] = 0;
         end
         m_raw2[b] = m_raw1[b];
      end
      m_raw1[0] = int'(i_btn_jump);
      m_raw1[1] = int'(i_btn_duck);
      if (i_animate) m_hits = 0;
      else if (i_collision && m_state == 2) m_hits = (m_hits + 1 > CMIN) ? CMIN : m_hits + 1;
      case (m_state)
         0: if (press == 1) begin
               m_state = 1; m_frames = 0; m_sub = 0; m_score = 0;
            end
         1: if (i_animate) begin
               m_frames = m_frames + 1;
               if (m_frames == GF) begin m_state = 2; m_frames = 0; end
            end
         2: if (dead_now == 1) begin
               m_state = 3; m_frames = 0; m_hits = 0;
               if (m_score > m_high) m_high = m_score;
            end else if (i_animate) begin
               m_sub = m_sub + 1;
               if (m_sub == DIV) begin
                  m_sub = 0;
                  if (m_score < SMAX) m_score = m_score + 1;
               end
            end
         default: if (press == 1 && m_frames == HOLD) begin
               m_state = 1; m_frames = 0; m_sub = 0; m_score = 0;
            end else if (i_animate && m_frames < HOLD) begin
               m_frames = m_frames + 1;
            end
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cmp_model();
      n_cmp++;
      if (int'(o_game_state) != m_state || int'(o_dino_jump) != m_ojump ||
          int'(o_dino_duck) != m_oduck || int'(o_score) != m_score ||
          int'(o_high_score) != m_high) begin
         n_bad++;
         $display("FAIL model @%0t: got st=%0d j=%0d d=%0d sc=%0d hi=%0d expected st=%0d j=%0d d=%0d sc=%0d hi=%0d",
                  $time, o_game_state, o_dino_jump, o_dino_duck, o_score, o_high_score,
                  m_state, m_ojump, m_oduck, m_score, m_high);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         model_step();
         @(posedge i_clk);
         @(negedge i_clk);
         cmp_model();
      end
   endtask

   typedef struct {
      string name;
      int    n;
      bit    rst_n, jump, duck, anim, coll;
      int    st, dj, dd, score, high;
   } vec_t;

   vec_t tbl [$];

   initial begin
      int pulses;

      i_rst_n = 1'b0; i_btn_jump = 1'b0; i_btn_duck = 1'b0; i_animate = 1'b0; i_collision = 1'b0;
      @(negedge i_clk);

      //               name            n  rs jp dk an co  st dj dd  sc  hi   (-1 = not checked)
      tbl.push_back('{"reset",          2, 0, 0, 0, 0, 0,  0, 0, 0,  0,  0});
      tbl.push_back('{"idle_start",     3, 1, 0, 0, 0, 0,  0, 0, 0,  0,  0});
      tbl.push_back('{"jump_deb_wait", 10, 1, 1, 0, 0, 0,  0, 0, 0,  0,  0});
      tbl.push_back('{"jump_start",     1, 1, 1, 0, 0, 0,  1, 0, 0,  0,  0});
      tbl.push_back('{"grace_anim1",    1, 1, 1, 0, 1, 1,  1, 0, 0,  0,  0});
      tbl.push_back('{"grace_gap",      2, 1, 1, 0, 0, 1,  1, 0, 0,  0,  0});
      tbl.push_back('{"grace_anim2",    1, 1, 1, 0, 1, 1,  1, 0, 0,  0,  0});
      tbl.push_back('{"grace_anim3",    1, 1, 1, 0, 1, 1,  2, 0, 0,  0,  0});
      tbl.push_back('{"play_score5",   10, 1, 1, 0, 1, 0,  2, 0, 0,  5,  0});
      tbl.push_back('{"coll3",          3, 1, 1, 0, 0, 1,  2, 0, 0,  5,  0});
      tbl.push_back('{"frame_clear",    1, 1, 1, 0, 1, 0,  2, 0, 0,  5,  0});
      tbl.push_back('{"coll4",          4, 1, 1, 0, 0, 1,  2, 0, 0,  5,  0});
      tbl.push_back('{"dead_enter",     1, 1, 1, 0, 0, 0,  3, 0, 0,  5, -1});
      tbl.push_back('{"dead_high",      1, 1, 1, 0, 0, 0,  3, 0, 0,  5,  5});
      tbl.push_back('{"jump_release",  12, 1, 0, 0, 0, 0,  3, 0, 0,  5,  5});
      tbl.push_back('{"dead_frame1",    1, 1, 0, 0, 1, 0,  3, 0, 0,  5,  5});
      tbl.push_back('{"early_jump",    11, 1, 1, 0, 0, 0,  3, 0, 0,  5,  5});
      tbl.push_back('{"jump_release2", 12, 1, 0, 0, 0, 0,  3, 0, 0,  5,  5});
      tbl.push_back('{"dead_frame_sat", 3, 1, 0, 0, 1, 0,  3, 0, 0,  5,  5});
      tbl.push_back('{"restart",       11, 1, 1, 0, 0, 0,  1, 0, 0,  0,  5});
      tbl.push_back('{"release3",      12, 1, 0, 0, 0, 0,  1, 0, 0,  0,  5});

      foreach (tbl[i]) begin
         i_rst_n = tbl[i].rst_n; i_btn_jump = tbl[i].jump; i_btn_duck = tbl[i].duck;
         i_animate = tbl[i].anim; i_collision = tbl[i].coll;
         cycles(tbl[i].n);
         check({tbl[i].name, "_state"}, int'(o_game_state), tbl[i].st);
         check({tbl[i].name, "_jump"},  int'(o_dino_jump),  tbl[i].dj);
         check({tbl[i].name, "_duck"},  int'(o_dino_duck),  tbl[i].dd);
         check({tbl[i].name, "_score"}, int'(o_score),      tbl[i].score);
         if (tbl[i].high >= 0) check({tbl[i].name, "_high"}, int'(o_high_score), tbl[i].high);
      end

      // bouncing button never settles long enough to register
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         i_btn_jump = ((i / 3) % 2) == 1;
         cycles(1);
         if (o_dino_jump) pulses++;
      end
      check("bounce_no_press", pulses, 0);
      check("bounce_state", int'(o_game_state), 1);
      i_btn_jump = 1'b1;
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         cycles(1);
         if (o_dino_jump) pulses++;
      end
      check("stable_one_press", pulses, 1);
      check("stable_state", int'(o_game_state), 1);

      // second game scores 3, high score must stay 5
      i_animate = 1'b1;
      cycles(3);
      check("game2_play", int'(o_game_state), 2);
      cycles(6);
      check("game2_score", int'(o_score), 3);
      i_animate = 1'b0; i_collision = 1'b1;
      cycles(4);
      i_collision = 1'b0;
      cycles(2);
      check("game2_dead", int'(o_game_state), 3);
      check("game2_high_kept", int'(o_high_score), 5);

      // mid-game reset with duck held
      i_btn_jump = 1'b0; i_btn_duck = 1'b1;
      cycles(12);
      i_animate = 1'b1;
      cycles(2);
      i_animate = 1'b0; i_btn_jump = 1'b1;
      cycles(11);
      check("game3_grace", int'(o_game_state), 1);
      i_animate = 1'b1;
      cycles(3);
      check("game3_play", int'(o_game_state), 2);
      check("game3_duck", int'(o_dino_duck), 1);
      cycles(14);
      check("game3_score7", int'(o_score), 7);
      i_animate = 1'b0; i_rst_n = 1'b0;
      cycles(1);
      check("midreset_state", int'(o_game_state), 0);
      check("midreset_score", int'(o_score), 0);
      check("midreset_high", int'(o_high_score), 0);
      check("midreset_duck", int'(o_dino_duck), 0);
      i_rst_n = 1'b1;
      cycles(1);
      check("postreset_duck", int'(o_dino_duck), 0);

      // held jump re-debounces after reset, then score saturates
      cycles(11);
      check("sat_grace", int'(o_game_state), 1);
      i_animate = 1'b1;
      cycles(3);
      cycles(40);
      check("sat_score", int'(o_score), SMAX);
      i_animate = 1'b0; i_collision = 1'b1;
      cycles(4);
      i_collision = 1'b0;
      cycles(2);
      check("sat_dead", int'(o_game_state), 3);
      check("sat_high", int'(o_high_score), SMAX);

      // random stimulus against the model
      for (int i = 0; i < 4000; i++) begin
         i_rst_n = ($urandom_range(0, 499) != 0);
         if ($urandom_range(0, 15) == 0) i_btn_jump = ~i_btn_jump;
         if ($urandom_range(0, 19) == 0) i_btn_duck = ~i_btn_duck;
         i_animate   = ($urandom_range(0, 3) == 0);
         i_collision = ($urandom_range(0, 2) == 0);
         cycles(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
